// File: rtl/lcd_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lcd_pkg : font geometry, panel defaults and one-hot sequencer states
// Rev 1.0
// ----------------------------------------------------------------------------
package lcd_pkg;

  localparam int FONT_W0    = 6;
  localparam int FONT_H0    = 12;
  localparam int FONT_W1    = 8;
  localparam int FONT_H1    = 16;
  localparam int LCD_W_DFLT = 240;
  localparam int LCD_H_DFLT = 320;

  localparam logic [6:0] ASCII_LF = 7'h0A;

  typedef enum logic [7:0] {
    ST_IDLE      = 8'b0000_0001,
    ST_FETCH     = 8'b0000_0010,
    ST_WAIT_Q    = 8'b0000_0100,
    ST_PLACE     = 8'b0000_1000,
    ST_ISSUE     = 8'b0001_0000,
    ST_WAIT_DONE = 8'b0010_0000,
    ST_NEXT      = 8'b0100_0000,
    ST_DONE      = 8'b1000_0000
  } str_state_t;

  // Once y is already below the panel it stops growing, so runs of newlines cannot wrap 10 bits.
  function automatic logic [9:0] line_down(input logic [9:0] y, input logic [4:0] h,
                                           input logic [9:0] lim);
    return (y > lim) ? y : y + {5'd0, h};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_show_string.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lcd_show_string : walks an external ASCII buffer and issues one glyph request
//                   per printable character, handling wrap, newline and bottom edge
// Rev 1.0
// ----------------------------------------------------------------------------
module lcd_show_string
  import lcd_pkg::*;
#(
  parameter int LCD_W = LCD_W_DFLT,
  parameter int LCD_H = LCD_H_DFLT,
  parameter int LEN_W = 6
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             str_start,
  input  logic [LEN_W-1:0] str_len,
  input  logic [8:0]       str_x,
  input  logic [8:0]       str_y,
  input  logic             str_size,
  output logic [LEN_W-1:0] buf_addr,
  input  logic [6:0]       buf_data,
  output logic             show_char_flag,
  output logic [6:0]       ascii_num,
  output logic [8:0]       char_x,
  output logic [8:0]       char_y,
  output logic             en_size,
  input  logic             show_char_done,
  output logic             busy,
  output logic             str_done,
  output logic             str_ovf
);

  localparam logic [9:0] c_LCD_W = 10'(LCD_W);
  localparam logic [9:0] c_LCD_H = 10'(LCD_H);

  str_state_t       r_state, w_state_nxt;
  logic [LEN_W-1:0] r_len, r_idx;
  logic [8:0]       r_org_x;
  logic [9:0]       r_cur_x, r_cur_y;
  logic [6:0]       r_ascii;
  logic             r_size, r_ovf, r_wrapped;
  logic [4:0]       w_gw, w_gh;
  logic [9:0]       w_x_end, w_y_end, w_y_nl;
  logic             w_x_fail, w_y_fail, w_is_lf, w_last;

  always_comb begin
    w_gw = r_size ? 5'(FONT_W1) : 5'(FONT_W0);
    w_gh = r_size ? 5'(FONT_H1) : 5'(FONT_H0);
  end

  assign w_x_end  = r_cur_x + {5'd0, w_gw};
  assign w_y_end  = r_cur_y + {5'd0, w_gh};
  assign w_x_fail = w_x_end > c_LCD_W;
  assign w_y_fail = w_y_end > c_LCD_H;
  assign w_y_nl   = line_down(r_cur_y, w_gh, c_LCD_H);
  assign w_is_lf  = (r_ascii == ASCII_LF);
  assign w_last   = ((r_idx + LEN_W'(1)) == r_len);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (str_start) w_state_nxt = (str_len == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH:     w_state_nxt = ST_WAIT_Q;
      ST_WAIT_Q:    w_state_nxt = ST_PLACE;
      ST_PLACE: begin
        if (w_is_lf)       w_state_nxt = ST_NEXT;
        else if (w_x_fail) w_state_nxt = r_wrapped ? ST_DONE : ST_PLACE;
        else if (w_y_fail) w_state_nxt = ST_DONE;
        else               w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE:     w_state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (show_char_done) w_state_nxt = ST_NEXT;
      ST_NEXT:      w_state_nxt = w_last ? ST_DONE : ST_FETCH;
      ST_DONE:      w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    show_char_flag = 1'b0;
    str_done       = 1'b0;
    busy           = 1'b1;
    case (r_state)
      ST_IDLE:  busy           = 1'b0;
      ST_ISSUE: show_char_flag = 1'b1;
      ST_DONE:  str_done       = 1'b1;
      default:  ;
    endcase
  end

  // r_wrapped marks that this glyph already wrapped once; a second x failure means str_x itself cannot fit.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_len     <= '0;
      r_idx     <= '0;
      r_org_x   <= '0;
      r_cur_x   <= '0;
      r_cur_y   <= '0;
      r_ascii   <= '0;
      r_size    <= 1'b0;
      r_ovf     <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (str_start) begin
          r_len     <= str_len;
          r_idx     <= '0;
          r_org_x   <= str_x;
          r_cur_x   <= {1'b0, str_x};
          r_cur_y   <= {1'b0, str_y};
          r_size    <= str_size;
          r_ovf     <= 1'b0;
          r_wrapped <= 1'b0;
        end
        ST_FETCH:  r_wrapped <= 1'b0;
        ST_WAIT_Q: r_ascii   <= buf_data;
        ST_PLACE: begin
          if (w_is_lf) begin
            r_cur_x <= {1'b0, r_org_x};
            r_cur_y <= w_y_nl;
          end else if (w_x_fail) begin
            if (r_wrapped) begin
              r_ovf <= 1'b1;
            end else begin
              r_cur_x   <= {1'b0, r_org_x};
              r_cur_y   <= w_y_nl;
              r_wrapped <= 1'b1;
            end
          end else if (w_y_fail) begin
            r_ovf <= 1'b1;
          end
        end
        ST_WAIT_DONE: if (show_char_done) r_cur_x <= w_x_end;
        ST_NEXT:      r_idx <= r_idx + LEN_W'(1);
        default: ;
      endcase
    end
  end

  assign buf_addr  = r_idx;
  assign ascii_num = r_ascii;
  assign char_x    = r_cur_x[8:0];
  assign char_y    = r_cur_y[8:0];
  assign en_size   = r_size;
  assign str_ovf   = r_ovf;

endmodule
`default_nettype wire
